// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with write-to-read bypass, optional
// hardwired zero register and a per-register busy scoreboard for RAW detection.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*ADDR_W-1:0] raddr,
  output logic [NREAD*DATA_W-1:0] rdata,
  output logic [NREAD-1:0]        rbusy,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    issue_en,
  input  logic [ADDR_W-1:0]       issue_addr,
  output logic [ADDR_W:0]         busy_cnt
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam int CNT_W    = ADDR_W + 1;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH-1:0]        busy;
  logic [DEPTH-1:0]        busy_next;
  logic [CNT_W-1:0]        cnt_next;
  logic                    wvalid;
  logic                    ivalid;
  logic [ADDR_W-1:0]       ra;
  logic [NREAD*DATA_W-1:0] rdata_next;
  logic [NREAD-1:0]        rbusy_next;

  // Writes and issues aimed at a hardwired r0 are dropped before they touch any state.
  // NOTE: combinational blocks use blocking '=' so later statements see the updated value.
  always_comb begin
    wvalid = we && !(HAS_ZERO && waddr == '0);
    ivalid = issue_en && !(HAS_ZERO && issue_addr == '0);
  end

  // Issue is OR-ed in after the release, so a same-cycle issue+write keeps the register busy.
  always_comb begin
    busy_next = '0;
    cnt_next  = '0;
    for (int r = 0; r < DEPTH; r++) begin
      busy_next[r] = (busy[r] && !(wvalid && waddr == ADDR_W'(r)))
                   || (ivalid && issue_addr == ADDR_W'(r));
      cnt_next     = cnt_next + CNT_W'(busy_next[r]);
    end
  end

  always_comb begin
    rdata_next = '0;
    rbusy_next = '0;
    ra         = '0;
    for (int i = 0; i < NREAD; i++) begin
      ra = raddr[i*ADDR_W +: ADDR_W];
      if (HAS_ZERO && ra == '0)
        rdata_next[i*DATA_W +: DATA_W] = '0;
      else if (wvalid && waddr == ra)
        rdata_next[i*DATA_W +: DATA_W] = wdata;
      else
        rdata_next[i*DATA_W +: DATA_W] = mem[ra];
      rbusy_next[i] = busy_next[ra];
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every entry must read 0 after reset, so the array is cleared explicitly;
      // this rules out a plain RAM macro and maps the file onto flops.
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
      busy     <= '0;
      rdata    <= '0;
      rbusy    <= '0;
      busy_cnt <= '0;
    end else begin
      if (wvalid) mem[waddr] <= wdata;
      busy     <= busy_next;
      rdata    <= rdata_next;
      rbusy    <= rbusy_next;
      busy_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a 3-port ZERO_REG=1 instance plus a 1-port
// ZERO_REG=0 instance sharing the write/issue buses.
module tb_regfile_mp;

  typedef enum {K_RDATA, K_RBUSY, K_CNT, K_ZDATA, K_ZBUSY, K_ZCNT} kind_e;
  typedef struct {
    int          due;
    kind_e       kind;
    int          port;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] raddr;
  logic [95:0] rdata;
  logic [2:0]  rbusy;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [5:0]  busy_cnt;
  logic [4:0]  rz;
  logic [31:0] zdata;
  logic [0:0]  zbusy;
  logic [5:0]  zcnt;

  exp_t q[$];
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(3), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_cnt(busy_cnt)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(1), .ZERO_REG(0)) dut_z (
    .clk(clk), .rst(rst), .raddr(rz), .rdata(zdata), .rbusy(zbusy),
    .we(we), .waddr(waddr), .wdata(wdata),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_cnt(zcnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Expectations are due on the negedge after the next rising edge.
  task automatic ex(input string name, input kind_e kind, input int port, input logic [31:0] val);
    exp_t e;
    e.due  = cyc_cnt + 1;
    e.kind = kind;
    e.port = port;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    raddr = {a2, a1, a0};
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
  endtask

  task automatic iss(input logic [4:0] a);
    issue_en   = 1'b1;
    issue_addr = a;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    we       = 1'b0;
    issue_en = 1'b0;
    rst      = 1'b0;
  endtask

  // Monitor: pops every expectation due this cycle and compares it to the DUT outputs.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0 && q[0].due <= cyc_cnt) begin
      e = q.pop_front();
      case (e.kind)
        K_RDATA: act = rdata[e.port*32 +: 32];
        K_RBUSY: act = {29'b0, rbusy};
        K_CNT:   act = {26'b0, busy_cnt};
        K_ZDATA: act = zdata;
        K_ZBUSY: act = {31'b0, zbusy};
        default: act = {26'b0, zcnt};
      endcase
      checks++;
      if (act !== e.val || e.due != cyc_cnt) begin
        errors++;
        $display("FAIL %s: got %h expected %h (due cycle %0d, seen %0d)",
                 e.name, act, e.val, e.due, cyc_cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    issue_en = 1'b0; issue_addr = '0; raddr = '0; rz = '0;
    @(negedge clk);

    // Reset held: everything reads zero.
    rst = 1'b1; rd(0, 0, 0);
    ex("rst_rd0", K_RDATA, 0, 32'h0); ex("rst_rd1", K_RDATA, 1, 32'h0);
    ex("rst_rd2", K_RDATA, 2, 32'h0); ex("rst_busy", K_RBUSY, 0, 32'h0);
    ex("rst_cnt", K_CNT, 0, 32'h0);   ex("rst_z", K_ZDATA, 0, 32'h0);
    next_cycle();

    // Reset clear of a written entry.
    wr(5, 32'hDEADBEEF); rd(5, 0, 0);
    ex("r5_bypass", K_RDATA, 0, 32'hDEADBEEF);
    next_cycle();
    rst = 1'b1; rd(5, 0, 0);
    ex("r5_in_rst", K_RDATA, 0, 32'h0); ex("cnt_in_rst", K_CNT, 0, 32'h0);
    next_cycle();
    rd(5, 0, 0);
    ex("r5_cleared", K_RDATA, 0, 32'h0); ex("busy_cleared", K_RBUSY, 0, 32'h0);
    ex("cnt_cleared", K_CNT, 0, 32'h0);
    next_cycle();

    // Basic three-port read.
    wr(1, 32'h11); next_cycle();
    wr(2, 32'h22); next_cycle();
    wr(3, 32'h33); next_cycle();
    rd(1, 2, 3); rz = 5'd3;
    ex("rd_r1", K_RDATA, 0, 32'h11); ex("rd_r2", K_RDATA, 1, 32'h22);
    ex("rd_r3", K_RDATA, 2, 32'h33); ex("z_rd_r3", K_ZDATA, 0, 32'h33);
    next_cycle();

    // Bypass on two ports, third port unaffected; stored value afterwards.
    wr(7, 32'h1); next_cycle();
    wr(7, 32'hA5A5A5A5); rd(7, 7, 1);
    ex("byp_p0", K_RDATA, 0, 32'hA5A5A5A5); ex("byp_p1", K_RDATA, 1, 32'hA5A5A5A5);
    ex("byp_p2_other", K_RDATA, 2, 32'h11);
    next_cycle();
    rd(0, 0, 7);
    ex("r7_stored", K_RDATA, 2, 32'hA5A5A5A5);
    next_cycle();

    // Zero register: hardwired on dut, ordinary on dut_z.
    wr(0, 32'hFFFFFFFF); iss(0); rd(0, 0, 0); rz = 5'd0;
    ex("r0_wr_byp", K_RDATA, 0, 32'h0); ex("r0_busy", K_RBUSY, 0, 32'h0);
    ex("r0_cnt", K_CNT, 0, 32'h0);      ex("z_r0_byp", K_ZDATA, 0, 32'hFFFFFFFF);
    ex("z_r0_busy", K_ZBUSY, 0, 32'h1); ex("z_r0_cnt", K_ZCNT, 0, 32'h1);
    next_cycle();
    rd(0, 0, 0); rz = 5'd0;
    ex("r0_after", K_RDATA, 0, 32'h0); ex("z_r0_after", K_ZDATA, 0, 32'hFFFFFFFF);
    next_cycle();

    // Busy scoreboard: issue, issue+write, write release.
    iss(4); rd(4, 0, 0);
    ex("iss_r4_busy", K_RBUSY, 0, 32'h1); ex("iss_r4_cnt", K_CNT, 0, 32'h1);
    next_cycle();
    wr(4, 32'h44); iss(4); rd(4, 4, 0);
    ex("reiss_busy", K_RBUSY, 0, 32'h3); ex("reiss_cnt", K_CNT, 0, 32'h1);
    ex("reiss_data", K_RDATA, 0, 32'h44);
    next_cycle();
    wr(4, 32'h45); rd(4, 4, 0);
    ex("rel_busy", K_RBUSY, 0, 32'h0); ex("rel_cnt", K_CNT, 0, 32'h0);
    ex("rel_data", K_RDATA, 1, 32'h45);
    next_cycle();

    // Reset mid-flight discards busy state and a concurrent write.
    iss(8); rd(8, 0, 0);
    ex("r8_busy", K_RBUSY, 0, 32'h1); ex("cnt1", K_CNT, 0, 32'h1);
    next_cycle();
    iss(9); rd(8, 9, 0);
    ex("r9_busy", K_RBUSY, 0, 32'h3); ex("cnt2", K_CNT, 0, 32'h2);
    next_cycle();
    iss(10); rd(8, 9, 10);
    ex("r10_busy", K_RBUSY, 0, 32'h7); ex("cnt3", K_CNT, 0, 32'h3);
    next_cycle();
    rst = 1'b1; wr(8, 32'h88); rd(8, 9, 10);
    ex("mid_rst_busy", K_RBUSY, 0, 32'h0); ex("mid_rst_cnt", K_CNT, 0, 32'h0);
    ex("mid_rst_rd0", K_RDATA, 0, 32'h0);
    next_cycle();
    rd(8, 9, 10);
    ex("post_rst_r8", K_RDATA, 0, 32'h0); ex("post_rst_busy", K_RBUSY, 0, 32'h0);
    ex("post_rst_cnt", K_CNT, 0, 32'h0);
    next_cycle();

    // Highest address.
    wr(31, 32'h31313131); iss(31); rd(31, 0, 0);
    ex("r31_byp", K_RDATA, 0, 32'h31313131); ex("r31_busy", K_RBUSY, 0, 32'h1);
    ex("r31_cnt", K_CNT, 0, 32'h1);
    next_cycle();
    rd(31, 0, 0);
    ex("r31_stored", K_RDATA, 0, 32'h31313131); ex("r31_busy_hold", K_RBUSY, 0, 32'h1);
    ex("r31_cnt_hold", K_CNT, 0, 32'h1);
    next_cycle();

    repeat (3) next_cycle();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port register file for the pipelined core. It generalises the 2-read/1-write file with:
- configurable data width, depth and read-port count;
- posedge-registered reads with write-to-read bypass;
- synchronous clear;
- an optional hardwired zero register;
- a per-register busy scoreboard, so decode can detect RAW hazards against in-flight producers.

It sits between decode (reads, issue marking) and writeback (writes, busy release).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NREAD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and never becomes busy

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
raddr  input  NREAD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
rdata  output  NREAD*DATA_W  packed registered read data; port i = bits [i*DATA_W +: DATA_W]
rbusy  output  NREAD  registered busy flag of each read port's address
we  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  DATA_W  write data
issue_en  input  1  mark issue_addr busy (a producer entered the pipe)
issue_addr  input  ADDR_W  destination register of issuing instruction
busy_cnt  output  ADDR_W+1  registered count of busy registers

Behaviour:
- Reset, rst=1 at a rising edge:
  - all entries cleared to 0; all busy bits cleared;
  - rdata=0, rbusy=0, busy_cnt=0;
  - rst overrides we and issue_en in the same cycle.
- Write:
  - wvalid = we && !(ZERO_REG && waddr==0).
  - If wvalid, mem[waddr] <= wdata at the edge.
- Busy update, computed per register r:
  - busy_next[r] = (busy[r] && !(wvalid && waddr==r)) || (ivalid && issue_addr==r).
  - ivalid = issue_en && !(ZERO_REG && issue_addr==0).
  - Issue and write to the same register in one cycle: issue wins, and the register stays busy (a new producer).
- Read, latency 1 cycle, every port every cycle, no enable:
  - rdata_i <= (wvalid && waddr==raddr_i) ? wdata : mem[raddr_i]. Same-cycle write is bypassed, never stale.
  - ZERO_REG && raddr_i==0 -> rdata_i <= 0, regardless of any write.
  - rbusy_i <= busy_next[raddr_i]. The flag reflects this cycle's issue and release.
  - Ports are fully independent; several ports may read the same address.
- busy_cnt <= popcount(busy_next). Range 0..2**ADDR_W, or 2**ADDR_W-1 when ZERO_REG=1; it never wraps.
- Out-of-range addresses cannot occur, because depth = 2**ADDR_W.
- Reset mid-operation: pending busy state is discarded. The first cycle after rst deasserts returns 0 on all ports.
- No negedge logic and no combinational read path. Outputs change only on the rising edge.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, pulse rst one cycle, read r5 -> rdata=0, rbusy=0, busy_cnt=0 one cycle after rst.
- Basic write/read, NREAD=3: write r1=0x11, r2=0x22, r3=0x33; then raddr={r3,r2,r1} -> next cycle rdata={0x33,0x22,0x11}.
- Bypass: raddr0=r7 while we=1, waddr=r7, wdata=0xA5A5A5A5, old value 0x1 -> next cycle rdata0=0xA5A5A5A5; mem[r7]=0xA5A5A5A5 afterwards.
- Zero register, ZERO_REG=1: we=1, waddr=0, wdata=0xFFFFFFFF, issue_en=1, issue_addr=0 -> rdata for r0=0, rbusy=0, busy_cnt unchanged. With ZERO_REG=0, r0 reads 0xFFFFFFFF on the following read.
- Scoreboard: issue r4 -> rbusy(r4)=1, busy_cnt=1. Write r4 while issuing r4 again -> rbusy stays 1, busy_cnt=1. Write r4 alone -> rbusy=0, busy_cnt=0.
- Reset mid-flight: issue r8, r9, r10 (busy_cnt=3), assert rst during a concurrent write to r8 -> busy_cnt=0, r8 reads 0, all rbusy=0.
